// File: rtl/painel_pkg.sv
// Shared mode codes and sequencer states for the panel scroll controller.
package painel_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE
    } state_t;

endpackage

// File: rtl/painel_tick_div.sv
// Loadable prescaler: tick while the count sits at zero, then auto-reload.
module painel_tick_div #(
    parameter int CNT_W = 27
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             reload,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (reload || cnt == '0) begin
            cnt <= period;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/painel_scroll_ctrl.sv
// Mode sequencer for the circular letter registers: load, paced rotation,
// pause/resume and single-pass scrolling.
module painel_scroll_ctrl
    import painel_pkg::*;
#(
    parameter int DIV_BASE = 12_500_000,
    parameter int WIDTH    = 16,
    parameter int CNT_W    = 27
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    input  logic                     dir,
    input  logic                     single,
    input  logic [1:0]               speed,
    output logic                     ch0,
    output logic                     ch1,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     busy,
    output logic                     done
);

    localparam int PW = $clog2(WIDTH);
    localparam int SW = $clog2(WIDTH + 1);

    state_t           st;
    state_t           st_n;
    logic [1:0]       mode;
    logic [1:0]       mode_n;
    logic [PW-1:0]    pos_n;
    logic [PW-1:0]    pos_inc;
    logic [PW-1:0]    pos_dec;
    logic [SW-1:0]    step;
    logic [SW-1:0]    step_n;
    logic             done_n;
    logic             single_q;
    logic             single_n;
    logic             reload;
    logic             tick;
    logic [CNT_W-1:0] period;

    // Reload value is one less than the period; the zero cycle is the tick.
    assign period = (CNT_W'(DIV_BASE) << speed) - CNT_W'(1);

    assign pos_inc = (pos == PW'(WIDTH - 1)) ? '0 : pos + PW'(1);
    assign pos_dec = (pos == '0) ? PW'(WIDTH - 1) : pos - PW'(1);

    painel_tick_div #(
        .CNT_W(CNT_W)
    ) u_div (
        .CLK   (CLK),
        .RST   (RST),
        .reload(reload),
        .period(period),
        .tick  (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st       <= IDLE;
            mode     <= MODE_HOLD;
            pos      <= '0;
            step     <= '0;
            done     <= 1'b0;
            single_q <= 1'b0;
        end else begin
            st       <= st_n;
            mode     <= mode_n;
            pos      <= pos_n;
            step     <= step_n;
            done     <= done_n;
            single_q <= single_n;
        end
    end

    always_comb begin
        st_n     = st;
        mode_n   = MODE_HOLD;
        pos_n    = pos;
        step_n   = step;
        done_n   = 1'b0;
        single_n = single_q;
        reload   = 1'b0;
        if (clear) begin
            st_n  = IDLE;
            pos_n = '0;
        end else begin
            unique case (st)
                IDLE: begin
                    // Reloading here makes the LOAD cycle the first
                    // cycle of the first shift period.
                    if (start) begin
                        st_n     = LOAD;
                        mode_n   = MODE_LOAD;
                        pos_n    = '0;
                        step_n   = '0;
                        single_n = single;
                        reload   = 1'b1;
                    end
                end
                LOAD: begin
                    st_n = RUN;
                end
                RUN: begin
                    if (stop) begin
                        st_n = PAUSE;
                    end else if (tick) begin
                        mode_n = dir ? MODE_SHR : MODE_SHL;
                        pos_n  = dir ? pos_dec : pos_inc;
                        step_n = step + SW'(1);
                        if (single_q && step_n == SW'(WIDTH)) begin
                            done_n = 1'b1;
                            st_n   = IDLE;
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && start) begin
                        st_n   = RUN;
                        reload = 1'b1;
                    end
                end
            endcase
        end
    end

    assign ch0  = mode[0];
    assign ch1  = mode[1];
    assign busy = (st != IDLE);

endmodule

// File: tb/tb_painel_scroll_ctrl.sv
// Self-checking bench for painel_scroll_ctrl with DIV_BASE=4, WIDTH=16.
module tb_painel_scroll_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       dir = 1'b0;
    logic       single = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       ch0, ch1, busy, done;
    logic [3:0] pos;

    int nchk = 0;
    int nerr = 0;

    painel_scroll_ctrl #(
        .DIV_BASE(4),
        .WIDTH   (16),
        .CNT_W   (8)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .stop  (stop),
        .clear (clear),
        .dir   (dir),
        .single(single),
        .speed (speed),
        .ch0   (ch0),
        .ch1   (ch1),
        .pos   (pos),
        .busy  (busy),
        .done  (done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       s;
        logic       p;
        logic       c;
        logic [1:0] mode;
        logic [3:0] pos;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tv[19];

    // Reference model state: spec-level states and absolute shift times.
    int     m_st;
    int     m_pos;
    int     m_steps;
    bit     m_single;
    int     m_mode;
    bit     m_done;
    longint cyc;
    longint due;

    function automatic logic [7:0] obs();
        return {ch1, ch0, pos, busy, done};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc1(input logic s, input logic p, input logic c);
        @(negedge CLK);
        start = s;
        stop  = p;
        clear = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge CLK);
        RST      = 1'b0;
        m_st     = 0;
        m_pos    = 0;
        m_steps  = 0;
        m_single = 0;
        m_mode   = 0;
        m_done   = 0;
        cyc      = 0;
        due      = 0;
    endtask

    task automatic model_edge();
        int p;
        p      = 4 << speed;
        m_mode = 0;
        m_done = 0;
        if (clear) begin
            m_st  = 0;
            m_pos = 0;
        end else begin
            case (m_st)
                0: if (start) begin
                    m_st     = 1;
                    m_mode   = 3;
                    m_pos    = 0;
                    m_steps  = 0;
                    m_single = single;
                    due      = cyc + 1 + p;
                end
                1: m_st = 2;
                2: if (stop) begin
                    m_st = 3;
                end else if (cyc + 1 == due) begin
                    m_mode = dir ? 2 : 1;
                    m_pos  = (m_pos + (dir ? 15 : 1)) % 16;
                    m_steps++;
                    due = cyc + 1 + p;
                    if (m_single && m_steps == 16) begin
                        m_done = 1;
                        m_st   = 0;
                    end
                end
                3: if (!stop && start) begin
                    m_st = 2;
                    due  = cyc + 1 + p;
                end
                default: m_st = 0;
            endcase
        end
        cyc++;
    endtask

    initial begin
        int k_a, k_b, p_a, p_b, nsh, k;
        logic got_done;
        logic [7:0] exp8;

        tv[0]  = '{1, 0, 0, 2'b11, 4'd0, 1, 0};
        tv[1]  = '{0, 0, 0, 2'b00, 4'd0, 1, 0};
        tv[2]  = '{0, 0, 0, 2'b00, 4'd0, 1, 0};
        tv[3]  = '{0, 0, 0, 2'b00, 4'd0, 1, 0};
        tv[4]  = '{0, 0, 0, 2'b01, 4'd1, 1, 0};
        tv[5]  = '{0, 0, 0, 2'b00, 4'd1, 1, 0};
        tv[6]  = '{0, 0, 0, 2'b00, 4'd1, 1, 0};
        tv[7]  = '{0, 0, 0, 2'b00, 4'd1, 1, 0};
        tv[8]  = '{0, 0, 0, 2'b01, 4'd2, 1, 0};
        tv[9]  = '{0, 1, 0, 2'b00, 4'd2, 1, 0};
        tv[10] = '{0, 0, 0, 2'b00, 4'd2, 1, 0};
        tv[11] = '{0, 0, 0, 2'b00, 4'd2, 1, 0};
        tv[12] = '{1, 0, 0, 2'b00, 4'd2, 1, 0};
        tv[13] = '{0, 0, 0, 2'b00, 4'd2, 1, 0};
        tv[14] = '{0, 0, 0, 2'b00, 4'd2, 1, 0};
        tv[15] = '{0, 0, 0, 2'b00, 4'd2, 1, 0};
        tv[16] = '{0, 0, 0, 2'b01, 4'd3, 1, 0};
        tv[17] = '{0, 0, 1, 2'b00, 4'd0, 0, 0};
        tv[18] = '{0, 0, 0, 2'b00, 4'd0, 0, 0};

        do_reset();
        #1;
        chk("reset_state", obs(), 8'h00);

        // Table: load, left shifts, pause/resume, clear.
        for (int i = 0; i < 19; i++) begin
            cyc1(tv[i].s, tv[i].p, tv[i].c);
            exp8 = {tv[i].mode, tv[i].pos, tv[i].busy, tv[i].done};
            chk($sformatf("table[%0d]", i), obs(), exp8);
        end

        // speed=2, dir=1: 16-cycle spacing, right shift with wrap.
        do_reset();
        speed = 2'd2;
        dir   = 1'b1;
        cyc1(1, 0, 0);
        chk("r_load", {ch1, ch0}, 2'b11);
        k_a = -1; k_b = -1; p_a = -1; p_b = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc1(0, 0, 0);
            if ({ch1, ch0} == 2'b10) begin
                if (k_a < 0) begin
                    k_a = i; p_a = pos;
                end else if (k_b < 0) begin
                    k_b = i; p_b = pos;
                end
            end
        end
        chk("r_first_at", k_a, 16);
        chk("r_gap", k_b - k_a, 16);
        chk("r_pos_wrap", p_a, 15);
        chk("r_pos_2nd", p_b, 14);

        // Single pass: single is latched at start, then dropped.
        do_reset();
        speed  = 2'd0;
        dir    = 1'b0;
        single = 1'b1;
        cyc1(1, 0, 0);
        single   = 1'b0;
        nsh      = 0;
        got_done = 1'b0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            cyc1(0, 0, 0);
            if ({ch1, ch0} == 2'b01) nsh++;
            if (done) begin
                got_done = 1'b1;
                chk("sp_pos", pos, 4'd0);
                chk("sp_busy_at_done", busy, 1'b0);
            end
        end
        chk("sp_done_seen", got_done, 1'b1);
        chk("sp_shift_count", nsh, 16);
        nsh = 0;
        for (int i = 0; i < 12; i++) begin
            cyc1(0, 0, 0);
            if ({ch1, ch0} != 2'b00 || done) nsh++;
        end
        chk("sp_idle_after", {nsh[7:0], busy}, 9'h0);

        // stop in the same cycle as the terminal count.
        do_reset();
        cyc1(1, 0, 0);
        cyc1(0, 0, 0);
        cyc1(0, 0, 0);
        cyc1(0, 0, 0);
        cyc1(0, 1, 0);
        chk("tc_stop", obs(), {2'b00, 4'd0, 1'b1, 1'b0});
        nsh = 0;
        for (int i = 0; i < 10; i++) begin
            cyc1(0, 0, 0);
            if ({ch1, ch0} != 2'b00) nsh++;
        end
        chk("tc_paused_quiet", nsh, 0);
        cyc1(1, 0, 0);
        k = -1;
        for (int i = 1; i <= 8 && k < 0; i++) begin
            cyc1(0, 0, 0);
            if ({ch1, ch0} == 2'b01) k = i;
        end
        chk("tc_resume_at", k, 4);
        chk("tc_resume_pos", pos, 4'd1);

        // Asynchronous reset during RUN.
        do_reset();
        cyc1(1, 0, 0);
        repeat (6) cyc1(0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_async", obs(), 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        cyc1(1, 0, 0);
        chk("rst_reload", obs(), {2'b11, 4'd0, 1'b1, 1'b0});

        // Randomized run against the reference model.
        do_reset();
        dir   = 1'b0;
        speed = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            start  = ($urandom % 8) == 0;
            stop   = ($urandom % 30) == 0;
            clear  = ($urandom % 150) == 0;
            single = $urandom % 2;
            if ($urandom % 16 == 0) dir = ~dir;
            if ($urandom % 25 == 0) speed = 2'($urandom % 4);
            @(posedge CLK);
            model_edge();
            #1;
            exp8 = {m_mode[1:0], m_pos[3:0], (m_st != 0), m_done};
            chk($sformatf("rand[%0d]", i), obs(), exp8);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
